// File: rtl/mult_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_unit_pkg
// Shared definitions for the iterative shift-and-add multiplier: operand
// width, step count, counter width and the FSM state encoding.
// -----------------------------------------------------------------------------
package mult_unit_pkg;

  // Operand and result-byte width. Only 8 is supported.
  localparam int WIDTH     = 8;

  // One RUN step per multiplier bit.
  localparam int MUL_STEPS = 8;

  localparam int CNT_W     = $clog2(MUL_STEPS);

  // A step taken while the counter holds this value is the final step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  // 2'b11 is unused and is recovered to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_unit_if.sv
// -----------------------------------------------------------------------------
// mult_unit_if
// Request/result bundle between the control unit (master) and the
// multiplier (slave).
//   start        : request a multiply, sampled on the rising clock edge
//   multiplicand : operand A, sampled with an accepted start
//   multiplier   : operand B, sampled with an accepted start
//   busy         : high while the multiply is stepping
//   done         : one-cycle pulse, product valid from this cycle on
//   result       : low byte of the 16-bit product
//   product_hi   : high byte of the 16-bit product
//   overflow     : product does not fit in 8 bits
// -----------------------------------------------------------------------------
interface mult_unit_if;
  import mult_unit_pkg::*;

  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] product_hi;
  logic             overflow;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, result, product_hi, overflow
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, result, product_hi, overflow
  );

endinterface

// File: rtl/mult_step.sv
// -----------------------------------------------------------------------------
// mult_step
// One combinational shift-and-add step.
//   acc         : partial product in
//   mcand       : zero-extended multiplicand, already shifted for this step
//   mplier      : remaining multiplier bits, bit 0 is the current one
//   acc_nxt     : acc + mcand when mplier[0] is set, else acc
//   mcand_nxt   : mcand logically shifted left by one
//   mplier_nxt  : mplier logically shifted right by one
// -----------------------------------------------------------------------------
module mult_step
  import mult_unit_pkg::*;
(
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);

  // An 8x8 product always fits in 16 bits, so the add never carries out.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/mult_unit.sv
// -----------------------------------------------------------------------------
// mult_unit
// Iterative 8x8 shift-and-add multiplier. An accepted start loads the
// operands, eight RUN cycles accumulate the product one multiplier bit at a
// time, and a single DONE cycle pulses done. The product registers feed the
// outputs directly and hold until the next accepted start clears them.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mult_unit_if slave modport (start/operands in,
//              busy/done/result/product_hi/overflow out)
// -----------------------------------------------------------------------------
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  mult_unit_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;

  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mcand_step;
  logic [WIDTH-1:0]   mplier_step;

  // Datapath controls decoded from the FSM.
  logic               load;   // accept start: capture operands, clear acc
  logic               step;   // one shift-and-add step
  logic               clear;  // recovery from the unused encoding

  mult_step u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_step),
    .mcand_nxt  (mcand_step),
    .mplier_nxt (mplier_step)
  );

  // NOTE: state-holding blocks use non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal gets a default before the case; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // start is ignored here; RUN always takes all eight steps.
        step = 1'b1;
        if (count == LAST_STEP) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        // Back-to-back: a start in DONE is accepted exactly as in IDLE.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        clear     = 1'b0 | 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are few and feed the outputs directly, so
  // they are reset too; this makes the outputs read zero during reset and
  // after a mid-operation abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.multiplicand};
      mplier <= bus.multiplier;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_step;
      mcand  <= mcand_step;
      mplier <= mplier_step;
      count  <= count + CNT_W'(1);
    end else if (clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end
  end

  // Outputs come straight from registers; nothing combinational from inputs.
  assign bus.busy       = (state == ST_RUN);
  assign bus.done       = (state == ST_DONE);
  assign bus.result     = acc[WIDTH-1:0];
  assign bus.product_hi = acc[2*WIDTH-1:WIDTH];
  assign bus.overflow   = |acc[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_unit
// Self-checking bench for mult_unit: a table of directed products, hand
// sequences for the multi-cycle corner cases, and randomized operands checked
// against plain integer multiplication.
// -----------------------------------------------------------------------------
module tb_mult_unit;

  logic clk;
  logic reset_n;

  mult_unit_if bus ();

  mult_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request and let the next rising edge accept it. The caller
  // makes sure this is called away from the rising edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    // Operands are don't-care once accepted.
    bus.multiplicand = 8'($urandom);
    bus.multiplier   = 8'($urandom);
  endtask

  // Sample on falling edges until done; exp_edges counts rising edges
  // from the point of call up to and including the one that raises done.
  task automatic wait_done(input string tag, input int exp_edges);
    int edges  = 0;
    int busy_n = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      edges++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_edges - 1));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_prod(input string tag, input logic [15:0] p);
    check({tag, "_result"}, 32'(bus.result), 32'(p[7:0]));
    check({tag, "_product_hi"}, 32'(bus.product_hi), 32'(p[15:8]));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(p[15:8] != 8'h00));
  endtask

  // done is a single pulse and the product holds in IDLE.
  task automatic check_idle_hold(input string tag, input logic [15:0] p);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_hold"}, 32'({bus.product_hi, bus.result}), 32'(p));
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] model;
    int          done_cnt;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   lo: 8'h0F, hi: 8'h00, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF,  b: 8'hFF,  lo: 8'h01, hi: 8'hFE, ovf: 1'b1};
    vecs[2] = '{a: 8'd16,  b: 8'd16,  lo: 8'h00, hi: 8'h01, ovf: 1'b1};
    vecs[3] = '{a: 8'h2A,  b: 8'h00,  lo: 8'h00, hi: 8'h00, ovf: 1'b0};
    vecs[4] = '{a: 8'h00,  b: 8'h2A,  lo: 8'h00, hi: 8'h00, ovf: 1'b0};
    vecs[5] = '{a: 8'h80,  b: 8'h02,  lo: 8'h00, hi: 8'h01, ovf: 1'b1};
    vecs[6] = '{a: 8'd15,  b: 8'd17,  lo: 8'hFF, hi: 8'h00, ovf: 1'b0};
    vecs[7] = '{a: 8'h01,  b: 8'hB7,  lo: 8'hB7, hi: 8'h00, ovf: 1'b0};

    bus.start        = 1'b0;
    bus.multiplicand = 8'h00;
    bus.multiplier   = 8'h00;
    reset_n          = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'({bus.overflow, bus.product_hi, bus.result}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({bus.busy, bus.done}), 32'd0);

    // Directed table: start at E0, done after E8 (9 edges counting E0).
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(vecs[i].a, vecs[i].b);
      wait_done(tag, 9);
      check({tag, "_result"}, 32'(bus.result), 32'(vecs[i].lo));
      check({tag, "_product_hi"}, 32'(bus.product_hi), 32'(vecs[i].hi));
      check({tag, "_overflow"}, 32'(bus.overflow), 32'(vecs[i].ovf));
      check_idle_hold(tag, {vecs[i].hi, vecs[i].lo});
    end

    // start during RUN is ignored: 7x6 started, 2x2 requested at E3.
    @(negedge clk);
    start_op(8'd7, 8'd6);
    repeat (3) @(negedge clk);
    start_op(8'd2, 8'd2);
    wait_done("ignore", 6);
    check_prod("ignore", 16'd42);
    check_idle_hold("ignore", 16'd42);

    // Reset after E4 of 9x9 aborts immediately and no done follows.
    @(negedge clk);
    start_op(8'd9, 8'd9);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'({bus.overflow, bus.product_hi, bus.result}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    start_op(8'd9, 8'd9);
    wait_done("after_abort", 9);
    check_prod("after_abort", 16'h0051);
    check_idle_hold("after_abort", 16'h0051);

    // Back-to-back: 2x3, then 4x4 requested in the DONE cycle.
    @(negedge clk);
    start_op(8'd2, 8'd3);
    wait_done("b2b_first", 9);
    check_prod("b2b_first", 16'h0006);
    start_op(8'd4, 8'd4);
    wait_done("b2b_second", 9);
    check_prod("b2b_second", 16'h0010);
    check_idle_hold("b2b_second", 16'h0010);

    // Randomized operands, sometimes restarted straight from DONE.
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      string tag;
      tag   = $sformatf("rnd%0d", i);
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      model = 16'(ra) * 16'(rb);
      start_op(ra, rb);
      wait_done(tag, 9);
      check_prod(tag, model);
      if ($urandom_range(0, 1) == 0) check_idle_hold(tag, model);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
